// File: rtl/uart_frame_assembler_if.sv
// Byte-stream input and frame output bundle for the UART frame assembler.
// The producer/consumer side uses master, the assembler uses slave.
interface uart_frame_assembler_if #(
  parameter int IMG_WIDTH  = 40,
  parameter int IMG_HEIGHT = 30
);
  logic [7:0]                                 rx_data;
  logic                                       rx_valid;
  logic                                       det_busy;
  logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0]  laptop_img;
  logic                                       laptop_img_rdy;
  logic                                       frame_err;
  logic                                       frame_dropped;
  logic [15:0]                                frame_count;

  modport master (
    output rx_data, rx_valid, det_busy,
    input  laptop_img, laptop_img_rdy, frame_err, frame_dropped, frame_count
  );

  modport slave (
    input  rx_data, rx_valid, det_busy,
    output laptop_img, laptop_img_rdy, frame_err, frame_dropped, frame_count
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Collects a sync-headed, checksummed grayscale frame from the UART byte stream
// into a shadow buffer and publishes it to detect_face on a one-cycle strobe.
module uart_frame_assembler #(
  parameter int         IMG_WIDTH      = 40,
  parameter int         IMG_HEIGHT     = 30,
  parameter logic [7:0] SYNC0          = 8'hA5,
  parameter logic [7:0] SYNC1          = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_frame_assembler_if.slave  bus
);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] img_t;
  typedef enum logic [2:0] {WAIT_S0, WAIT_S1, PIXELS, CHECK, COMMIT} state_t;

  state_t          state_q, state_d;
  img_t            shadow_q, shadow_d;
  img_t            img_q, img_d;
  logic [7:0]      sum_q, sum_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [15:0]     count_q, count_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic            timed_out;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    img_d     = img_q;
    sum_d     = sum_q;
    row_d     = row_q;
    col_d     = col_q;
    tmo_d     = '0;
    count_d   = count_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    timed_out = 1'b0;

    // Inter-byte watchdog; an arriving byte always clears it, so it wins a tie.
    if ((state_q == WAIT_S1 || state_q == PIXELS || state_q == CHECK) && !bus.rx_valid) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) timed_out = 1'b1;
      else                                  tmo_d     = tmo_q + 1'b1;
    end
    if (timed_out) begin
      err_d   = 1'b1;
      state_d = WAIT_S0;
    end

    case (state_q)
      WAIT_S0: if (bus.rx_valid && bus.rx_data == SYNC0) state_d = WAIT_S1;
      WAIT_S1: if (bus.rx_valid) begin
        if (bus.rx_data == SYNC1) begin
          state_d = PIXELS;
          row_d   = '0;
          col_d   = '0;
          sum_d   = '0;
        end else if (bus.rx_data != SYNC0) begin
          state_d = WAIT_S0;
        end
      end
      PIXELS: if (bus.rx_valid) begin
        shadow_d[row_q][col_q] = bus.rx_data;
        sum_d = sum_q + bus.rx_data;
        if (col_q == CW'(IMG_WIDTH - 1)) begin
          col_d = '0;
          if (row_q == RW'(IMG_HEIGHT - 1)) begin
            row_d   = '0;
            state_d = CHECK;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      CHECK: if (bus.rx_valid) begin
        if (bus.rx_data == sum_q) begin
          state_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = WAIT_S0;
        end
      end
      COMMIT: begin
        if (bus.det_busy) begin
          drop_d = 1'b1;
        end else begin
          img_d   = shadow_q;
          rdy_d   = 1'b1;
          count_d = count_q + 1'b1;
        end
        // A byte landing here is treated as the start of the next header hunt.
        state_d = (bus.rx_valid && bus.rx_data == SYNC0) ? WAIT_S1 : WAIT_S0;
      end
      default: state_d = WAIT_S0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_S0;
      shadow_q <= '0;
      img_q    <= '0;
      sum_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tmo_q    <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      img_q    <= img_d;
      sum_q    <= sum_d;
      row_q    <= row_d;
      col_q    <= col_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.laptop_img     = img_q;
  assign bus.laptop_img_rdy = rdy_q;
  assign bus.frame_err      = err_q;
  assign bus.frame_dropped  = drop_q;
  assign bus.frame_count    = count_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed and randomized frame streams checked against a header-scanning reference model.
module tb_uart_frame_assembler;
  localparam int W = 4;
  localparam int H = 3;
  localparam int T = 20;
  localparam int N = W * H;

  typedef logic [H-1:0][W-1:0][7:0] img_t;
  typedef logic [7:0] bytes_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_frame_assembler_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus();

  uart_frame_assembler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_rdy = 0, n_err = 0, n_drop = 0, n_overlap = 0;
  img_t ref_img;
  logic [15:0] ref_count;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.laptop_img_rdy === 1'b1) n_rdy++;
      if (bus.frame_err === 1'b1) n_err++;
      if (bus.frame_dropped === 1'b1) n_drop++;
      if ((int'(bus.laptop_img_rdy) + int'(bus.frame_err) + int'(bus.frame_dropped)) > 1) n_overlap++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    idle(1);
    bus.rx_valid = 1'b0;
  endtask

  // kind: 0 nothing, 1 commit, 2 checksum error, 3 dropped
  task automatic run_frame(input string tag, input bytes_t q, input logic busy, input int gap_max);
    int kind, start, r0, e0, d0;
    img_t pix;
    logic [7:0] sum;
    kind = 0;
    start = -1;
    pix = '0;
    for (int i = 0; i + 1 < q.size(); i++)
      if (start < 0 && q[i] == 8'hA5 && q[i+1] == 8'h5A) start = i + 2;
    if (start >= 0 && q.size() >= start + N + 1) begin
      sum = 8'd0;
      for (int p = 0; p < N; p++) begin
        pix[p / W][p % W] = q[start + p];
        sum = sum + q[start + p];
      end
      kind = (sum == q[start + N]) ? (busy ? 3 : 1) : 2;
    end
    r0 = n_rdy; e0 = n_err; d0 = n_drop;
    bus.det_busy = busy;
    foreach (q[i]) send_byte(q[i], $urandom_range(0, gap_max));
    idle(1);
    check({tag, "_rdy_latency"}, 128'(bus.laptop_img_rdy), 128'(kind == 1));
    check({tag, "_drop_latency"}, 128'(bus.frame_dropped), 128'(kind == 3));
    idle(1);
    bus.det_busy = 1'b0;
    if (kind == 1) begin
      ref_img = pix;
      ref_count = ref_count + 16'd1;
    end
    check({tag, "_rdy_pulses"}, 128'(n_rdy - r0), 128'(kind == 1));
    check({tag, "_err_pulses"}, 128'(n_err - e0), 128'(kind == 2));
    check({tag, "_drop_pulses"}, 128'(n_drop - d0), 128'(kind == 3));
    check({tag, "_img"}, 128'(bus.laptop_img), 128'(ref_img));
    check({tag, "_count"}, 128'(bus.frame_count), 128'(ref_count));
  endtask

  function automatic bytes_t good_seq();
    bytes_t q;
    q = '{8'hA5, 8'h5A};
    for (int p = 1; p <= N; p++) q.push_back(8'(p));
    q.push_back(8'h4E);
    return q;
  endfunction

  initial begin
    bytes_t q;
    logic [7:0] s;
    int r0, e0, d0, early;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.det_busy = 1'b0;
    ref_img   = '0;
    ref_count = 16'd0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_img", 128'(bus.laptop_img), 128'(0));
    check("reset_count", 128'(bus.frame_count), 128'(0));
    check("reset_pulses", 128'({bus.laptop_img_rdy, bus.frame_err, bus.frame_dropped}), 128'(0));

    // Good frame
    run_frame("good", good_seq(), 1'b0, 0);
    check("good_px00", 128'(bus.laptop_img[0][0]), 128'(8'd1));
    check("good_px23", 128'(bus.laptop_img[2][3]), 128'(8'd12));
    check("good_count1", 128'(bus.frame_count), 128'(16'd1));

    // Bad checksum
    q = good_seq();
    q[q.size()-1] = 8'h4F;
    run_frame("badchk", q, 1'b0, 0);

    // Noise and repeated sync
    q = '{8'h00, 8'hA5, 8'hA5, 8'h5A};
    for (int p = 0; p < N; p++) q.push_back(8'hFF);
    q.push_back(8'hF4);
    run_frame("noise", q, 1'b0, 0);
    check("noise_allff", 128'(bus.laptop_img), 128'({N{8'hFF}}));

    // Broken header: ignored, no error
    q = '{8'hA5, 8'h00, 8'h5A};
    for (int p = 0; p <= N; p++) q.push_back(8'h11);
    run_frame("badhdr", q, 1'b0, 0);

    // Stall after 5 pixels
    e0 = n_err;
    early = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    for (int p = 0; p < 5; p++) send_byte(8'h33, 0);
    for (int k = 1; k < T; k++) begin
      idle(1);
      if (bus.frame_err !== 1'b0) early++;
    end
    check("stall_no_early_err", 128'(early), 128'(0));
    idle(1);
    check("stall_err_at_limit", 128'(bus.frame_err), 128'(1));
    idle(1);
    check("stall_err_once", 128'(n_err - e0), 128'(1));
    run_frame("after_stall", good_seq(), 1'b0, 0);

    // Busy consumer
    run_frame("busy", good_seq(), 1'b1, 0);

    // Reset mid-PIXELS
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    for (int p = 0; p < 3; p++) send_byte(8'h77, 0);
    r0 = n_rdy; e0 = n_err; d0 = n_drop;
    reset = 1'b1;
    #1;
    check("midrst_img", 128'(bus.laptop_img), 128'(0));
    check("midrst_count", 128'(bus.frame_count), 128'(0));
    idle(2);
    reset = 1'b0;
    idle(T + 3);
    check("midrst_pulses", 128'((n_rdy - r0) + (n_err - e0) + (n_drop - d0)), 128'(0));
    ref_img = '0;
    ref_count = 16'd0;
    run_frame("post_rst", good_seq(), 1'b0, 0);
    check("post_rst_count1", 128'(bus.frame_count), 128'(16'd1));

    // Randomized frames with short inter-byte gaps
    for (int f = 0; f < 10; f++) begin
      q = {};
      if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom_range(0, 8'hA4)));
      q.push_back(8'hA5);
      q.push_back(8'h5A);
      s = 8'd0;
      for (int p = 0; p < N; p++) begin
        q.push_back(8'($urandom));
        s = s + q[q.size()-1];
      end
      if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
      q.push_back(s);
      run_frame($sformatf("rand%0d", f), q, ($urandom_range(0, 3) == 0), 3);
    end

    check("no_pulse_overlap", 128'(n_overlap), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
